// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial add/subtract unit, one full-adder slice, LSB first
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic             MODE,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CI,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] SUM,
   output logic             CO,
   output logic             OVF
);

   localparam int IDXW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_work;
   logic             r_carry;
   logic             r_cmsb;
   logic [IDXW-1:0]  r_idx;
   logic             r_done;
   logic [WIDTH-1:0] r_sum;
   logic             r_co;
   logic             r_ovf;

   logic             w_sum_bit;
   logic             w_carry;
   logic             w_last;
   logic             w_load;
   logic             w_run;
   logic             w_fin;

   assign w_sum_bit = r_a[0] ^ r_b[0] ^ r_carry;
   assign w_carry   = (r_a[0] & r_b[0]) | ((r_a[0] ^ r_b[0]) & r_carry);
   assign w_last    = (r_idx == IDXW'(WIDTH - 1));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (START)  w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_FIN;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_load = 1'b0;
      w_run  = 1'b0;
      w_fin  = 1'b0;
      case (r_state)
         S_IDLE:  w_load = START;
         S_RUN:   w_run  = 1'b1;
         S_FIN:   w_fin  = 1'b1;
         default: ;
      endcase
   end

   // Subtract is A + ~B + ~CI, so borrow-in folds into the initial carry.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_a     <= '0;
         r_b     <= '0;
         r_work  <= '0;
         r_carry <= 1'b0;
         r_cmsb  <= 1'b0;
         r_idx   <= '0;
      end else if (w_load) begin
         r_a     <= A;
         r_b     <= MODE ? ~B : B;
         r_carry <= CI ^ MODE;
         r_idx   <= '0;
      end else if (w_run) begin
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_work  <= (r_work >> 1) | (WIDTH'(w_sum_bit) << (WIDTH - 1));
         r_carry <= w_carry;
         if (w_last) r_cmsb <= r_carry;
         r_idx   <= r_idx + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_done <= 1'b0;
         r_sum  <= '0;
         r_co   <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         r_done <= w_fin;
         if (w_fin) begin
            r_sum <= r_work;
            r_co  <= r_carry;
            r_ovf <= r_cmsb ^ r_carry;
         end
      end
   end

   assign BUSY = w_run;
   assign DONE = r_done;
   assign SUM  = r_sum;
   assign CO   = r_co;
   assign OVF  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed vector bench for serial_adder (WIDTH=8 and WIDTH=1)
module tb_serial_adder;

   logic       CLK = 1'b0;
   logic       RST_N, START, MODE, CI;
   logic [7:0] A, B;
   logic       BUSY, DONE, CO, OVF;
   logic [7:0] SUM;

   logic       START1, MODE1, CI1;
   logic [0:0] A1, B1, SUM1;
   logic       BUSY1, DONE1, CO1, OVF1;

   int n_vec = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   serial_adder #(.WIDTH(8)) u_dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .MODE(MODE), .A(A), .B(B), .CI(CI),
      .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .CO(CO), .OVF(OVF)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .CLK(CLK), .RST_N(RST_N), .START(START1), .MODE(MODE1), .A(A1), .B(B1), .CI(CI1),
      .BUSY(BUSY1), .DONE(DONE1), .SUM(SUM1), .CO(CO1), .OVF(OVF1)
   );

   typedef struct {
      logic       mode;
      logic [7:0] a;
      logic [7:0] b;
      logic       ci;
      logic [7:0] sum;
      logic       co;
      logic       ovf;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Inputs are inverted right after the sampling edge to show they are not re-read.
   task automatic run_op(input logic mode, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, output logic [7:0] s, output logic co,
                         output logic ovf, output int done_at, output int busy_cnt,
                         output int hold_bad);
      logic [7:0] prev;
      @(negedge CLK);
      MODE = mode; A = a; B = b; CI = ci; START = 1'b1;
      prev = SUM;
      @(posedge CLK);
      busy_cnt = 0; done_at = -1; hold_bad = 0; s = 'x; co = 1'bx; ovf = 1'bx;
      for (int k = 0; k < 20 && done_at < 0; k++) begin
         @(negedge CLK);
         START = 1'b0;
         if (k == 0) begin A = ~A; B = ~B; CI = ~CI; MODE = ~MODE; end
         if (BUSY) busy_cnt++;
         if (DONE) begin
            done_at = k; s = SUM; co = CO; ovf = OVF;
         end else if (SUM !== prev) begin
            hold_bad++;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] s;
      logic       co, ovf;
      int         done_at, busy_cnt, hold_bad, dones, busy_late, width_bad, nd;
      int         d[4];
      logic       prev_done;

      vecs[0]  = '{1'b0, 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
      vecs[5]  = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[6]  = '{1'b1, 8'h05, 8'h05, 1'b1, 8'hFF, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[10] = '{1'b1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b0, 1'b1};

      RST_N = 1'b0; START = 1'b0; MODE = 1'b0; CI = 1'b0; A = '0; B = '0;
      START1 = 1'b0; MODE1 = 1'b0; CI1 = 1'b0; A1 = '0; B1 = '0;
      repeat (2) @(negedge CLK);
      check("reset busy", BUSY, 0);
      check("reset done", DONE, 0);
      check("reset sum", SUM, 0);
      check("reset co", CO, 0);
      check("reset ovf", OVF, 0);
      RST_N = 1'b1;

      for (int i = 0; i < 11; i++) begin
         run_op(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].ci, s, co, ovf,
                done_at, busy_cnt, hold_bad);
         check($sformatf("v%0d sum", i), s, vecs[i].sum);
         check($sformatf("v%0d co", i), co, vecs[i].co);
         check($sformatf("v%0d ovf", i), ovf, vecs[i].ovf);
         check($sformatf("v%0d latency", i), done_at, 9);
         check($sformatf("v%0d busy cycles", i), busy_cnt, 8);
         check($sformatf("v%0d result hold", i), hold_bad, 0);
         @(negedge CLK);
         check($sformatf("v%0d done pulse width", i), DONE, 0);
      end

      // START re-pulsed with new operands during RUN must be ignored
      @(negedge CLK);
      MODE = 1'b0; A = 8'h3C; B = 8'h05; CI = 1'b0; START = 1'b1;
      @(posedge CLK);
      dones = 0; busy_late = 0; s = 'x;
      for (int k = 0; k < 30; k++) begin
         @(negedge CLK);
         START = (k >= 2 && k <= 4);
         if (k == 2) begin A = 8'hFF; B = 8'hFF; MODE = 1'b1; CI = 1'b1; end
         if (DONE) begin dones++; s = SUM; end
         if (k >= 10 && BUSY) busy_late++;
      end
      check("restart ignored sum", s, 8'h41);
      check("restart ignored done count", dones, 1);
      check("restart ignored no second op", busy_late, 0);

      // Reset in the middle of RUN aborts and clears outputs immediately
      run_op(1'b0, 8'h3C, 8'h05, 1'b0, s, co, ovf, done_at, busy_cnt, hold_bad);
      check("pre-abort sum", s, 8'h41);
      @(negedge CLK);
      MODE = 1'b0; A = 8'h10; B = 8'h20; CI = 1'b0; START = 1'b1;
      @(posedge CLK);
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         START = 1'b0;
      end
      @(negedge CLK);
      check("abort busy before reset", BUSY, 1);
      RST_N = 1'b0;
      #1;
      check("abort busy", BUSY, 0);
      check("abort done", DONE, 0);
      check("abort sum", SUM, 0);
      check("abort co", CO, 0);
      dones = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         if (DONE) dones++;
      end
      check("abort no done", dones, 0);
      RST_N = 1'b1;
      run_op(1'b0, 8'h10, 8'h20, 1'b0, s, co, ovf, done_at, busy_cnt, hold_bad);
      check("post-abort sum", s, 8'h30);
      check("post-abort latency", done_at, 9);

      // START held high: an operation every WIDTH+2 cycles
      @(negedge CLK);
      MODE = 1'b0; A = 8'h01; B = 8'h02; CI = 1'b0; START = 1'b1;
      @(posedge CLK);
      nd = 0; width_bad = 0; prev_done = 1'b0; s = 'x;
      for (int k = 0; k < 42; k++) begin
         @(negedge CLK);
         if (DONE) begin
            if (nd < 4) d[nd] = k;
            nd++;
            s = SUM;
            if (prev_done) width_bad++;
         end
         prev_done = DONE;
      end
      START = 1'b0;
      check("b2b done count", nd, 4);
      check("b2b first done", d[0], 9);
      check("b2b period 1", d[1] - d[0], 10);
      check("b2b period 2", d[2] - d[1], 10);
      check("b2b period 3", d[3] - d[2], 10);
      check("b2b pulse width", width_bad, 0);
      check("b2b sum", s, 8'h03);
      repeat (12) @(negedge CLK);

      // WIDTH=1 instance: add 1+1+1, then subtract 0-1-0
      for (int t = 0; t < 2; t++) begin
         @(negedge CLK);
         MODE1 = (t == 1); A1 = (t == 0); B1 = 1'b1; CI1 = (t == 0); START1 = 1'b1;
         @(posedge CLK);
         done_at = -1; busy_cnt = 0; s = 'x; co = 1'bx; ovf = 1'bx;
         for (int k = 0; k < 8 && done_at < 0; k++) begin
            @(negedge CLK);
            START1 = 1'b0;
            if (BUSY1) busy_cnt++;
            if (DONE1) begin done_at = k; s = {7'd0, SUM1}; co = CO1; ovf = OVF1; end
         end
         check($sformatf("w1 t%0d latency", t), done_at, 2);
         check($sformatf("w1 t%0d busy cycles", t), busy_cnt, 1);
         check($sformatf("w1 t%0d sum", t), s, 1);
         check($sformatf("w1 t%0d co", t), co, (t == 0) ? 1 : 0);
         check($sformatf("w1 t%0d ovf", t), ovf, (t == 0) ? 0 : 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
